// File: rtl/main_mem_pkg.sv
// Shared types and default geometry for the main-memory model and the cache controller.
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mm_state_t;

    localparam int MM_CNT_W   = 8;
    localparam int MM_DATA_W  = 128;
    localparam int MM_ADDR_W  = 25;
    localparam int MM_DEPTH_W = 16;
    localparam int MM_LATENCY = 5;

endpackage

// File: rtl/main_mem_array.sv
// Single-port storage: synchronous write, asynchronous read, no reset.
// Kept separate so the storage can be swapped for an SRAM macro.
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int DATA_W  = MM_DATA_W,
    parameter int DEPTH_W = MM_DEPTH_W
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem_q [1<<DEPTH_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/main_mem_lat.sv
// Main-memory model with programmable access latency and valid/ready request/response handshake.
// Optional MAIN_MEM_ERR_EN: out-of-range addresses are rejected with rsp_err instead of aliasing.
module main_mem_lat
    import main_mem_pkg::*;
#(
    parameter int DATA_W  = MM_DATA_W,
    parameter int ADDR_W  = MM_ADDR_W,
    parameter int DEPTH_W = MM_DEPTH_W,
    parameter int LATENCY = MM_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

`ifdef MAIN_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    if (LATENCY < 1 || LATENCY > 255) begin : g_lat_check
        $error("main_mem_lat: LATENCY must lie in 1..255");
    end

    mm_state_t           state_q;
    logic [MM_CNT_W-1:0] cnt_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_we_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic                accept;
    logic                in_range;
    logic                addr_ok;
    logic                arr_we;
    logic [DATA_W-1:0]   arr_rdata;

    assign accept   = req_valid && req_ready_q && (state_q == IDLE);
    assign in_range = ((req_addr >> DEPTH_W) == '0);
    assign addr_ok  = !ERR_EN || in_range;
    assign arr_we   = accept && req_we && addr_ok;

    main_mem_array #(
        .DATA_W  (DATA_W),
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (req_addr[DEPTH_W-1:0]),
        .wdata (req_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        rsp_we_q    <= req_we;
                        rsp_err_q   <= !addr_ok;
                        rsp_rdata_q <= (!req_we && addr_ok) ? arr_rdata : '0;
                        cnt_q       <= MM_CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    // Response fields clear on consumption so rsp_err marks only its own response.
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        rsp_we_q    <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
